// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 2-of-3 majority vote,
// parity check and stop-bit framing check.
`timescale 1ns/1ps
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nx;
    logic [5:0]            p_lat;
    logic [5:0]            edge_cnt;
    logic [5:0]            half;
    logic [BW-1:0]         bit_cnt;
    logic                  par_en_lat;
    logic                  par_typ_lat;
    logic                  par_fail;
    logic [2:0]            smp;
    logic                  vote;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  bit_end;
    logic                  last_bit;
    logic                  start_go;
    logic                  frame_end;

    assign half     = {1'b0, p_lat[5:1]};
    assign bit_end  = (edge_cnt == p_lat - 6'd1);
    assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign vote     = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The last STOP cycle also watches for the next start bit,
    // so back-to-back frames need no idle gap.
    always_comb begin
        state_nx  = state;
        start_go  = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_nx = START;
                    start_go = 1'b1;
                end
            end
            START: begin
                if (bit_end) state_nx = vote ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end && last_bit) state_nx = par_en_lat ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_nx = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    frame_end = 1'b1;
                    if (!RX_IN) begin
                        state_nx = START;
                        start_go = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_lat       <= '0;
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            par_fail    <= 1'b0;
            smp         <= '0;
            shreg       <= '0;
            P_DATA      <= '0;
            Data_Valid  <= 1'b0;
            Par_Err     <= 1'b0;
            Stp_Err     <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            if (start_go) begin
                p_lat       <= Prescale;
                par_en_lat  <= PAR_EN;
                par_typ_lat <= PAR_TYP;
                edge_cnt    <= '0;
                bit_cnt     <= '0;
                par_fail    <= 1'b0;
            end else if (state != IDLE) begin
                edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
            end
            if (state != IDLE) begin
                if (edge_cnt == half - 6'd1) smp[0] <= RX_IN;
                if (edge_cnt == half)        smp[1] <= RX_IN;
                if (edge_cnt == half + 6'd1) smp[2] <= RX_IN;
            end
            if (state == DATA && bit_end) begin
                shreg   <= {vote, shreg[DATA_WIDTH-1:1]};
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (state == PARITY && bit_end) begin
                par_fail <= vote ^ (^shreg) ^ par_typ_lat;
            end
            if (frame_end) begin
                Par_Err <= par_fail;
                Stp_Err <= ~vote;
                if (!par_fail && vote) begin
                    Data_Valid <= 1'b1;
                    P_DATA     <= shreg;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with per-cycle strobe checking
// for the uart_rx receiver.
`timescale 1ns/1ps
module tb_uart_rx;
    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;

    int total = 0;
    int bad   = 0;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
        .Data_Valid(Data_Valid), .Par_Err(Par_Err), .Stp_Err(Stp_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0] ps;
        logic       pen;
        logic       pt;
        logic [7:0] data;
        logic       parbit;
        logic       stopbit;
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
    } vec_t;

    typedef struct {
        logic       v;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
    } exp_t;

    logic       rx_q  [0:1023];
    logic [5:0] ps_q  [0:1023];
    logic       pen_q [0:1023];
    logic       pt_q  [0:1023];
    exp_t       ex    [0:1023];
    vec_t       vt    [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clear_all(input logic [5:0] ps, input logic pen, input logic pt);
        for (int i = 0; i < 1024; i++) begin
            rx_q[i]  = 1'b1;
            ps_q[i]  = ps;
            pen_q[i] = pen;
            pt_q[i]  = pt;
            ex[i]    = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        end
    endtask

    task automatic put_frame(input int base, input int p, input logic pen,
                             input logic [7:0] d, input logic parbit,
                             input logic stopbit);
        int idx;
        for (int n = 0; n < p; n++) rx_q[base + n] = 1'b0;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < p; n++) rx_q[base + (k + 1) * p + n] = d[k];
        idx = 9;
        if (pen) begin
            for (int n = 0; n < p; n++) rx_q[base + 9 * p + n] = parbit;
            idx = 10;
        end
        for (int n = 0; n < p; n++) rx_q[base + idx * p + n] = stopbit;
    endtask

    task automatic expect_at(input int c, input logic dv, input logic pe,
                             input logic se, input logic [7:0] pd);
        ex[c] = '{1'b1, dv, pe, se, pd};
    endtask

    // Cycle n: outputs observed, then the inputs for cycle n applied.
    task automatic run(input int len, input string nm);
        int spur = 0;
        for (int n = 0; n < len; n++) begin
            @(negedge CLK);
            if (ex[n].v) begin
                chk({nm, " dv"}, 32'(Data_Valid), 32'(ex[n].dv));
                chk({nm, " pe"}, 32'(Par_Err), 32'(ex[n].pe));
                chk({nm, " se"}, 32'(Stp_Err), 32'(ex[n].se));
                chk({nm, " pdata"}, 32'(P_DATA), 32'(ex[n].pd));
            end else if (Data_Valid || Par_Err || Stp_Err) begin
                spur++;
            end
            RX_IN    = rx_q[n];
            Prescale = ps_q[n];
            PAR_EN   = pen_q[n];
            PAR_TYP  = pt_q[n];
        end
        chk({nm, " stray strobes"}, 32'(spur), 32'd0);
    endtask

    initial begin
        vt[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 81,  1'b1, 1'b0, 1'b0, 8'hA5};
        vt[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 177, 1'b1, 1'b0, 1'b0, 8'h3C};
        vt[2] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 177, 1'b0, 1'b1, 1'b0, 8'h3C};
        vt[3] = '{6'd32, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 353, 1'b0, 1'b0, 1'b1, 8'h3C};
        vt[4] = '{6'd8,  1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 89,  1'b1, 1'b0, 1'b0, 8'h00};
        vt[5] = '{6'd8,  1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 89,  1'b0, 1'b1, 1'b1, 8'h00};

        RST = 1'b0;
        RX_IN = 1'b1;
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        #12;
        chk("reset pdata", 32'(P_DATA), 32'd0);
        chk("reset dv", 32'(Data_Valid), 32'd0);
        chk("reset pe", 32'(Par_Err), 32'd0);
        chk("reset se", 32'(Stp_Err), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 6; i++) begin
            clear_all(vt[i].ps, vt[i].pen, vt[i].pt);
            put_frame(0, int'(vt[i].ps), vt[i].pen, vt[i].data,
                      vt[i].parbit, vt[i].stopbit);
            expect_at(vt[i].cyc, vt[i].dv, vt[i].pe, vt[i].se, vt[i].pd);
            run(vt[i].cyc + 6, $sformatf("vec%0d", i));
        end

        clear_all(6'd8, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) rx_q[n] = 1'b0;
        run(20, "short low pulse");

        clear_all(6'd8, 1'b0, 1'b0);
        put_frame(0, 8, 1'b0, 8'h5A, 1'b0, 1'b1);
        rx_q[37] = 1'b0;
        expect_at(81, 1'b1, 1'b0, 1'b0, 8'h5A);
        run(88, "centre glitch");

        clear_all(6'd8, 1'b0, 1'b0);
        put_frame(0, 8, 1'b0, 8'h12, 1'b0, 1'b1);
        put_frame(80, 8, 1'b0, 8'h34, 1'b0, 1'b1);
        for (int n = 30; n < 60; n++) begin
            ps_q[n]  = 6'd16;
            pen_q[n] = 1'b1;
        end
        expect_at(81, 1'b1, 1'b0, 1'b0, 8'h12);
        expect_at(161, 1'b1, 1'b0, 1'b0, 8'h34);
        run(170, "back to back");

        clear_all(6'd8, 1'b0, 1'b0);
        put_frame(0, 8, 1'b0, 8'hC3, 1'b0, 1'b1);
        run(40, "pre-reset frame");
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("midreset pdata", 32'(P_DATA), 32'd0);
        chk("midreset dv", 32'(Data_Valid), 32'd0);
        chk("midreset pe", 32'(Par_Err), 32'd0);
        chk("midreset se", 32'(Stp_Err), 32'd0);
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        clear_all(6'd8, 1'b0, 1'b0);
        put_frame(0, 8, 1'b0, 8'h81, 1'b0, 1'b1);
        expect_at(81, 1'b1, 1'b0, 1'b0, 8'h81);
        run(90, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
